// File: rtl/ieee_seq_multiplier.sv
// Iterative binary32 multiplier: radix-2 shift-and-add over 24 cycles, then one pack cycle.
// Truncating, flush-to-zero, same operand/result conventions as the FPU divider.
module ieee_seq_multiplier (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] out,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        PACK = 2'd2
    } state_t;

    state_t      state;
    logic        sign_q;
    logic [7:0]  ea_q;
    logic [7:0]  eb_q;
    logic [23:0] mcand_q;
    logic [23:0] mplier_q;
    logic        za_q, zb_q, ia_q, ib_q, na_q, nb_q;
    // Product accumulator; bit 0 is shifted out without ever being read, so it is not stored.
    logic [47:1] p_q;
    logic [4:0]  cnt_q;

    logic [24:0] upper_shift;
    logic [24:0] upper_next;

    always_comb begin
        upper_shift = {1'b0, p_q[47:24]};
        upper_next  = upper_shift;
        if (mplier_q[0]) begin
            upper_next = upper_shift + {1'b0, mcand_q};
        end
    end

    logic              norm;
    logic [22:0]       frac;
    logic signed [9:0] e_sum;
    logic              is_nan;
    logic [31:0]       pack_res;

    always_comb begin
        norm   = p_q[47];
        frac   = norm ? p_q[46:24] : p_q[45:23];
        e_sum  = signed'({2'b00, ea_q}) + signed'({2'b00, eb_q})
               + signed'({9'd0, norm}) - 10'sd127;
        is_nan = na_q | nb_q | (ia_q & zb_q) | (ib_q & za_q);
        if (is_nan) begin
            pack_res = 32'h7FC00000;
        end else if (ia_q | ib_q) begin
            pack_res = {sign_q, 8'hFF, 23'd0};
        end else if (za_q | zb_q) begin
            pack_res = {sign_q, 31'd0};
        end else if (e_sum >= 10'sd255) begin
            pack_res = {sign_q, 8'hFF, 23'd0};
        end else if (e_sum <= 10'sd0) begin
            pack_res = {sign_q, 31'd0};
        end else begin
            pack_res = {sign_q, e_sum[7:0], frac};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            out      <= 32'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            p_q      <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            ea_q     <= 8'd0;
            eb_q     <= 8'd0;
            mcand_q  <= 24'd0;
            mplier_q <= 24'd0;
            za_q     <= 1'b0;
            zb_q     <= 1'b0;
            ia_q     <= 1'b0;
            ib_q     <= 1'b0;
            na_q     <= 1'b0;
            nb_q     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_q   <= A[31] ^ B[31];
                        ea_q     <= A[30:23];
                        eb_q     <= B[30:23];
                        mcand_q  <= {1'b1, A[22:0]};
                        mplier_q <= {1'b1, B[22:0]};
                        za_q     <= (A[30:23] == 8'h00);
                        zb_q     <= (B[30:23] == 8'h00);
                        ia_q     <= (A[30:23] == 8'hFF) && (A[22:0] == 23'd0);
                        ib_q     <= (B[30:23] == 8'hFF) && (B[22:0] == 23'd0);
                        na_q     <= (A[30:23] == 8'hFF) && (A[22:0] != 23'd0);
                        nb_q     <= (B[30:23] == 8'hFF) && (B[22:0] != 23'd0);
                        p_q      <= '0;
                        cnt_q    <= '0;
                        busy     <= 1'b1;
                        state    <= MUL;
                    end
                end
                MUL: begin
                    p_q[47:23] <= upper_next;
                    p_q[22:1]  <= p_q[23:2];
                    mplier_q   <= {1'b0, mplier_q[23:1]};
                    cnt_q      <= cnt_q + 5'd1;
                    if (cnt_q == 5'd23) begin
                        state <= PACK;
                    end
                end
                PACK: begin
                    out   <= pack_res;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ieee_seq_multiplier.sv
// Bench for ieee_seq_multiplier: directed vectors, handshake/reset cases and a
// randomized pass scored against a full-width product reference.
module tb_ieee_seq_multiplier;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] out;
    logic        busy;
    logic        done;

    int n_checks;
    int n_pass;
    logic [31:0] exp_q[$];
    logic        prev_done;

    ieee_seq_multiplier dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .out   (out),
        .busy  (busy),
        .done  (done)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: exact 48-bit product, then truncate/pack with the special-case priority.
    function automatic logic [31:0] model_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s, za, zb, ia, ib, na, nb, n;
        logic [47:0] prod;
        logic [22:0] fr;
        int          e;
        s    = a[31] ^ b[31];
        za   = (a[30:23] == 8'h00);
        zb   = (b[30:23] == 8'h00);
        ia   = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        ib   = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        na   = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        nb   = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        prod = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        n    = prod[47];
        fr   = n ? prod[46:24] : prod[45:23];
        e    = int'(a[30:23]) + int'(b[30:23]) - 127 + int'(n);
        if (na || nb || (ia && zb) || (ib && za)) return 32'h7FC00000;
        if (ia || ib) return {s, 8'hFF, 23'd0};
        if (za || zb) return {s, 31'd0};
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, e[7:0], fr};
    endfunction

    // scoreboard: every done pulse must match the oldest expected result
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                check("result", out, exp_q.pop_front());
            end
            if (prev_done) begin
                check("done_two_cycles", 32'(prev_done), 32'd0);
            end
        end
        prev_done = done;
    end

    // One operation: start accepted at the next posedge; optional ignored start at N+5.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit glitch);
        int k;
        @(negedge clk);
        A = a;
        B = b;
        start = 1'b1;
        exp_q.push_back(exp);
        k = 0;
        while (k < 40) begin
            @(negedge clk);
            k++;
            if (k == 1) start = 1'b0;
            if (glitch && k == 5) begin
                A = ~a;
                B = b ^ 32'h00400000;
                start = 1'b1;
            end
            if (glitch && k == 6) start = 1'b0;
            if (done) break;
            check("busy_during_op", 32'(busy), 32'd1);
        end
        check("latency", 32'(k - 1), 32'd25);
        check("busy_at_done", 32'(busy), 32'd0);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] rand_operand();
        logic [7:0] e;
        int sel;
        sel = $urandom_range(0, 15);
        if (sel == 0) e = 8'h00;
        else if (sel == 1) e = 8'hFF;
        else e = 8'($urandom_range(90, 164));
        return {1'($urandom_range(0, 1)), e, 23'($urandom())};
    endfunction

    initial begin
        int k;
        logic [31:0] ra, rb;
        n_checks  = 0;
        n_pass    = 0;
        prev_done = 1'b0;
        rst   = 1'b1;
        start = 1'b0;
        A     = 32'd0;
        B     = 32'd0;
        idle_cycles(3);
        check("reset_out", out, 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        rst = 1'b0;

        // directed vectors
        do_op(32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0);
        do_op(32'h40400000, 32'h40400000, 32'h41100000, 1'b0);
        do_op(32'hC0000000, 32'h3F000000, 32'hBF800000, 1'b0);
        do_op(32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b0);
        do_op(32'h00800000, 32'h00800000, 32'h00000000, 1'b0);
        do_op(32'h00000000, 32'hC0400000, 32'h80000000, 1'b0);
        do_op(32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b0);
        do_op(32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0);
        do_op(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0);

        // start while busy is ignored
        do_op(32'h3FC00000, 32'h40000000, 32'h40400000, 1'b1);
        idle_cycles(30);

        // start held high: a new op accepted in each done cycle
        @(negedge clk);
        A = 32'h3FC00000;
        B = 32'h40000000;
        start = 1'b1;
        exp_q.push_back(32'h40400000);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            k = 1;
            while (!done && k < 60) begin
                @(negedge clk);
                k++;
            end
            check("held_start_gap", 32'(k), 32'd26);
            if (j == 0) begin
                A = 32'h40400000;
                B = 32'h40400000;
                exp_q.push_back(32'h41100000);
            end else if (j == 1) begin
                A = 32'hC0000000;
                B = 32'h3F000000;
                exp_q.push_back(32'hBF800000);
            end else begin
                start = 1'b0;
            end
        end
        idle_cycles(30);

        // reset at edge N+12 aborts the operation
        @(negedge clk);
        A = 32'h40400000;
        B = 32'h40400000;
        start = 1'b1;
        exp_q.push_back(32'h41100000);
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_out", out, 32'd0);
        check("abort_done", 32'(done), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        idle_cycles(30);
        do_op(32'hC0000000, 32'h3F000000, 32'hBF800000, 1'b0);

        // rst and start on the same edge: reset wins
        @(negedge clk);
        A = 32'h3FC00000;
        B = 32'h40000000;
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        check("rst_start_busy", 32'(busy), 32'd0);
        idle_cycles(30);
        check("rst_start_no_result", out, 32'd0);

        // randomized operands against the reference
        for (int i = 0; i < 20; i++) begin
            ra = rand_operand();
            rb = rand_operand();
            do_op(ra, rb, model_mul(ra, rb), 1'b0);
        end

        idle_cycles(5);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
